// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nand3_bist.sv
// Exhaustive Gray-order self-test of a NAND3 cell; ZN is checked against ~(A1&A2&A3).
// Define GF180MCU_FD_SC_MCU7T5V0_NAND3_BIST_STOP_ON_FAIL_EN to end the run on the first mismatch.
module gf180mcu_fd_sc_mcu7t5v0__nand3_bist #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned LOOPS         = 1,
  parameter int unsigned ERR_W         = 4
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  input  logic             ZN,
  output logic             A1,
  output logic             A2,
  output logic             A3,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [2:0]       FAIL_VEC,
  inout  wire              VDD,
  inout  wire              VSS
);

`ifdef GF180MCU_FD_SC_MCU7T5V0_NAND3_BIST_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam logic [3:0] SETTLE_INIT = 4'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
  localparam logic [7:0] LOOP_LAST   = 8'(LOOPS - 1);

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, FINISH} state_t;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       loop_q, loop_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       a_q, a_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [2:0]       fv_q, fv_d;
  logic             mism;
  logic             unused_supply;

  assign unused_supply = VDD ^ VSS;

  function automatic logic [2:0] gray(input logic [2:0] i);
    return i ^ (i >> 1);
  endfunction

  // Case inequality so an X/Z on ZN is scored as a mismatch.
  assign mism = (ZN !== ~(&a_q));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    loop_d  = loop_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fv_d    = fv_q;
    case (state_q)
      IDLE, FINISH: begin
        if (START) begin
          state_d = APPLY;
          idx_d   = '0;
          loop_d  = '0;
          err_d   = '0;
          fv_d    = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          a_d     = gray(3'd0);
        end
      end
      APPLY: begin
        if (SETTLE_CYCLES > 0) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_INIT;
        end else begin
          state_d = SAMPLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = SAMPLE;
        else             cnt_d   = cnt_q - 4'd1;
      end
      SAMPLE: begin
        if (mism) begin
          if (err_q != '1) err_d = err_q + 1'b1;
          if (err_q == '0) fv_d = a_q;
        end
        if (mism && STOP_ON_FAIL) begin
          state_d = FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b0;
        end else if (idx_q != 3'd7) begin
          state_d = APPLY;
          idx_d   = idx_q + 3'd1;
          a_d     = gray(idx_q + 3'd1);
        end else if (loop_q < LOOP_LAST) begin
          state_d = APPLY;
          idx_d   = '0;
          loop_d  = loop_q + 8'd1;
          a_d     = gray(3'd0);
        end else begin
          state_d = FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_q <= IDLE;
      idx_q   <= '0;
      loop_q  <= '0;
      cnt_q   <= '0;
      a_q     <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      loop_q  <= loop_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
    end
  end

  assign A1       = a_q[0];
  assign A2       = a_q[1];
  assign A3       = a_q[2];
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PASS     = pass_q;
  assign ERR_CNT  = err_q;
  assign FAIL_VEC = fv_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__nand3_bist.sv
// Directed bench: three BIST instances (default, SETTLE_CYCLES=0, LOOPS=3) against modelled NAND3 cells.
module tb_gf180mcu_fd_sc_mcu7t5v0__nand3_bist;

`ifdef GF180MCU_FD_SC_MCU7T5V0_NAND3_BIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rn = 1'b0;
  logic       start = 1'b0;
  int         zmode[3];
  logic       zn[3];
  logic       a1[3], a2[3], a3[3], busy[3], done[3], pass[3];
  logic [3:0] ec[3];
  logic [2:0] fv[3];
  wire        vdd, vss;
  int         checks = 0;
  int         errors = 0;
  int         done_at[3];
  logic [2:0] a_hist[128];
  logic [2:0] gray_tbl[8];

  assign vdd = 1'b1;
  assign vss = 1'b0;

  always #5 clk = ~clk;

  // Cell models: 0 ideal, 1 stuck-at-1, 2 stuck-at-0, 3 unknown
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      case (zmode[k])
        0:       zn[k] = ~(a1[k] & a2[k] & a3[k]);
        1:       zn[k] = 1'b1;
        2:       zn[k] = 1'b0;
        default: zn[k] = 1'bx;
      endcase
    end
  end

  gf180mcu_fd_sc_mcu7t5v0__nand3_bist dut0 (
    .CLK(clk), .RN(rn), .START(start), .ZN(zn[0]), .A1(a1[0]), .A2(a2[0]), .A3(a3[0]),
    .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]), .ERR_CNT(ec[0]), .FAIL_VEC(fv[0]),
    .VDD(vdd), .VSS(vss));

  gf180mcu_fd_sc_mcu7t5v0__nand3_bist #(.SETTLE_CYCLES(0)) dut1 (
    .CLK(clk), .RN(rn), .START(start), .ZN(zn[1]), .A1(a1[1]), .A2(a2[1]), .A3(a3[1]),
    .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]), .ERR_CNT(ec[1]), .FAIL_VEC(fv[1]),
    .VDD(vdd), .VSS(vss));

  gf180mcu_fd_sc_mcu7t5v0__nand3_bist #(.LOOPS(3)) dut2 (
    .CLK(clk), .RN(rn), .START(start), .ZN(zn[2]), .A1(a1[2]), .A2(a2[2]), .A3(a3[2]),
    .BUSY(busy[2]), .DONE(done[2]), .PASS(pass[2]), .ERR_CNT(ec[2]), .FAIL_VEC(fv[2]),
    .VDD(vdd), .VSS(vss));

  function automatic logic [2:0] avec(input int k);
    return {a3[k], a2[k], a1[k]};
  endfunction

  // All drives happen 1ns after a rising edge.
  task automatic do_reset();
    @(posedge clk); #1 rn = 1'b0;
    @(posedge clk); #1 rn = 1'b1;
  endtask

  task automatic go();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Records, per instance, the number of edges after acceptance at which DONE was first seen.
  task automatic measure();
    int n = 0;
    for (int k = 0; k < 3; k++) done_at[k] = -1;
    a_hist[0] = avec(0);
    while (n < 400 && (done_at[0] < 0 || done_at[1] < 0 || done_at[2] < 0)) begin
      @(posedge clk); #1;
      n++;
      if (n < 128) a_hist[n] = avec(0);
      for (int k = 0; k < 3; k++)
        if (done_at[k] < 0 && done[k] === 1'b1) done_at[k] = n;
    end
  endtask

  task automatic test_reset();
    zmode = '{0, 0, 0};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({avec(k), busy[k], done[k], pass[k], ec[k], fv[k]} !== 13'b111_000_0000_000) begin
        errors++;
        $display("FAIL reset_state[%0d]: got %b expected %b", k,
                 {avec(k), busy[k], done[k], pass[k], ec[k], fv[k]}, 13'b111_000_0000_000);
      end
    end
  endtask

  task automatic test_ideal();
    int exp_at[3] = '{32, 16, 96};
    zmode = '{0, 0, 0};
    do_reset();
    go();
    checks++;
    if ({busy[0], done[0], avec(0)} !== 5'b10_000) begin
      errors++;
      $display("FAIL ideal_accept: got %b expected %b", {busy[0], done[0], avec(0)}, 5'b10_000);
    end
    measure();
    for (int v = 0; v < 8; v++) begin
      checks++;
      if (a_hist[4*v] !== gray_tbl[v]) begin
        errors++;
        $display("FAIL ideal_gray[%0d]: got %b expected %b", v, a_hist[4*v], gray_tbl[v]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (done_at[k] != exp_at[k]) begin
        errors++;
        $display("FAIL ideal_done_cycle[%0d]: got %0d expected %0d", k, done_at[k], exp_at[k]);
      end
      checks++;
      if ({pass[k], busy[k], ec[k], fv[k]} !== 9'b10_0000_000) begin
        errors++;
        $display("FAIL ideal_result[%0d]: got %b expected %b", k,
                 {pass[k], busy[k], ec[k], fv[k]}, 9'b10_0000_000);
      end
    end
    checks++;
    if (avec(0) !== 3'b100) begin
      errors++;
      $display("FAIL ideal_final_vec: got %b expected %b", avec(0), 3'b100);
    end
  endtask

  task automatic test_stuck1();
    int         exp_at0 = STOP ? 24 : 32;
    int         exp_at1 = STOP ? 12 : 16;
    logic [2:0] exp_a   = STOP ? 3'b111 : 3'b100;
    zmode = '{1, 1, 0};
    do_reset();
    go();
    measure();
    checks++;
    if (done_at[0] != exp_at0) begin
      errors++;
      $display("FAIL stuck1_done_cycle: got %0d expected %0d", done_at[0], exp_at0);
    end
    checks++;
    if (done_at[1] != exp_at1) begin
      errors++;
      $display("FAIL stuck1_s0_done_cycle: got %0d expected %0d", done_at[1], exp_at1);
    end
    checks++;
    if ({pass[0], ec[0], fv[0], avec(0)} !== {1'b0, 4'd1, 3'b111, exp_a}) begin
      errors++;
      $display("FAIL stuck1_result: got %b expected %b",
               {pass[0], ec[0], fv[0], avec(0)}, {1'b0, 4'd1, 3'b111, exp_a});
    end
  endtask

  task automatic test_stuck0();
    int         exp_at2 = STOP ? 4 : 96;
    int         exp_at1 = STOP ? 2 : 16;
    logic [3:0] exp_ec2 = STOP ? 4'd1 : 4'd15;
    logic [3:0] exp_ec1 = STOP ? 4'd1 : 4'd7;
    logic [2:0] exp_a   = STOP ? 3'b000 : 3'b100;
    zmode = '{0, 2, 2};
    do_reset();
    go();
    measure();
    checks++;
    if (done_at[2] != exp_at2) begin
      errors++;
      $display("FAIL stuck0_loops3_done_cycle: got %0d expected %0d", done_at[2], exp_at2);
    end
    checks++;
    if ({pass[2], ec[2], fv[2], avec(2)} !== {1'b0, exp_ec2, 3'b000, exp_a}) begin
      errors++;
      $display("FAIL stuck0_loops3_result: got %b expected %b",
               {pass[2], ec[2], fv[2], avec(2)}, {1'b0, exp_ec2, 3'b000, exp_a});
    end
    checks++;
    if (done_at[1] != exp_at1) begin
      errors++;
      $display("FAIL stuck0_s0_done_cycle: got %0d expected %0d", done_at[1], exp_at1);
    end
    checks++;
    if ({pass[1], ec[1], fv[1]} !== {1'b0, exp_ec1, 3'b000}) begin
      errors++;
      $display("FAIL stuck0_s0_result: got %b expected %b",
               {pass[1], ec[1], fv[1]}, {1'b0, exp_ec1, 3'b000});
    end
  endtask

  task automatic test_unknown();
    zmode = '{0, 3, 0};
    do_reset();
    go();
    measure();
    if (!STOP) begin
      checks++;
      if (done_at[1] != 16) begin
        errors++;
        $display("FAIL unknown_done_cycle: got %0d expected %0d", done_at[1], 16);
      end
    end
    checks++;
    if ({done[1], pass[1]} !== 2'b10) begin
      errors++;
      $display("FAIL unknown_result: got %b expected %b", {done[1], pass[1]}, 2'b10);
    end
  endtask

  task automatic test_reset_mid_run();
    zmode = '{0, 0, 0};
    do_reset();
    go();
    repeat (8) begin @(posedge clk); #1; end
    rn = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({avec(k), busy[k], done[k], pass[k], ec[k], fv[k]} !== 13'b111_000_0000_000) begin
        errors++;
        $display("FAIL midrun_reset[%0d]: got %b expected %b", k,
                 {avec(k), busy[k], done[k], pass[k], ec[k], fv[k]}, 13'b111_000_0000_000);
      end
    end
    rn = 1'b1;
    go();
    measure();
    checks++;
    if (done_at[0] != 32 || pass[0] !== 1'b1 || ec[0] !== 4'd0) begin
      errors++;
      $display("FAIL midrun_rerun: got cycle=%0d pass=%b err=%0d expected cycle=32 pass=1 err=0",
               done_at[0], pass[0], ec[0]);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int exp_at = STOP ? 24 : 32;
    zmode = '{1, 0, 0};
    do_reset();
    go();
    while (n < 400 && done[0] !== 1'b1) begin
      start = (n == 4 || n == 19);
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (n == 5) begin
        checks++;
        if (busy[0] !== 1'b1) begin
          errors++;
          $display("FAIL b2b_busy_at_5: got %b expected %b", busy[0], 1'b1);
        end
      end
    end
    checks++;
    if (n != exp_at) begin
      errors++;
      $display("FAIL b2b_done_cycle: got %0d expected %0d", n, exp_at);
    end
    checks++;
    if (ec[0] !== 4'd1) begin
      errors++;
      $display("FAIL b2b_err_before_restart: got %0d expected %0d", ec[0], 1);
    end
    go();
    checks++;
    if ({done[0], busy[0], ec[0], fv[0], avec(0)} !== 12'b01_0000_000_000) begin
      errors++;
      $display("FAIL b2b_restart: got %b expected %b",
               {done[0], busy[0], ec[0], fv[0], avec(0)}, 12'b01_0000_000_000);
    end
  endtask

  initial begin
    gray_tbl = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    zmode = '{0, 0, 0};
    test_reset();
    test_ideal();
    test_stuck1();
    test_stuck0();
    test_unknown();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
